// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared definitions for the fetch-PC sequencer.
//   XLEN_DEFAULT         - default address width
//   RESET_VECTOR_DEFAULT - default PC loaded on reset
//   seq_state_e          - sequencer state encoding (BOOT/RUN/HALT)
//   redir_src_e          - redirect source encoding, used for debug/trace
package pc_sequencer_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } seq_state_e;

  typedef enum logic [2:0] {
    SRC_NONE   = 3'd0,
    SRC_TRAP   = 3'd1,
    SRC_MRET   = 3'd2,
    SRC_JUMP   = 3'd3,
    SRC_BRANCH = 3'd4
  } redir_src_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch handshake between the PC sequencer and the IF stage.
//   pc_valid    - pc is a valid fetch address (sequencer -> IF)
//   pc          - current fetch PC (sequencer -> IF)
//   fetch_ready - IF accepts pc this cycle (IF -> sequencer)
// master = sequencer side, slave = IF stage side.
interface pc_sequencer_if
  import pc_sequencer_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) ();

  logic            pc_valid;
  logic [XLEN-1:0] pc;
  logic            fetch_ready;

  modport master (
    output pc_valid,
    output pc,
    input  fetch_ready
  );

  modport slave (
    input  pc_valid,
    input  pc,
    output fetch_ready
  );

endinterface

// File: rtl/pc_target_arbiter.sv
// pc_target_arbiter: combinational redirect arbitration.
// Picks the highest-priority redirect (trap > mret > jump > branch),
// computes its target and flags jump/branch targets that break
// instruction alignment.
//   inputs : trap/mret/jump/branch requests and their address operands
//   sel        - winning redirect source (SRC_NONE if no request)
//   target     - target address of the winning source
//   misaligned - winning jump/branch target is not aligned
module pc_target_arbiter
  import pc_sequencer_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int IALIGN = 32
) (
  input  logic            trapped,
  input  logic [XLEN-1:0] trap_target,
  input  logic            trap_return,
  input  logic [XLEN-1:0] epc,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_base,
  input  logic [XLEN-1:0] branch_offset,
  output redir_src_e      sel,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  // Ones in the address bits that must be zero for an aligned fetch.
  localparam logic [XLEN-1:0] LOW_BITS = (IALIGN == 16) ? XLEN'(1) : XLEN'(3);

  logic [XLEN-1:0] branch_sum;

  // Carry out of the branch add is discarded: targets wrap modulo 2^XLEN.
  assign branch_sum = branch_base + branch_offset;

  always_comb begin
    sel        = SRC_NONE;
    target     = '0;
    misaligned = 1'b0;
    if (trapped) begin
      sel    = SRC_TRAP;
      target = trap_target & ~LOW_BITS;
    end else if (trap_return) begin
      sel    = SRC_MRET;
      target = epc & ~LOW_BITS;
    end else if (jump) begin
      sel        = SRC_JUMP;
      target     = jump_target;
      misaligned = (jump_target & LOW_BITS) != '0;
    end else if (branch_taken) begin
      sel        = SRC_BRANCH;
      target     = branch_sum;
      misaligned = (branch_sum & LOW_BITS) != '0;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered next-PC unit.
// Owns the fetch PC, offers it to IF over a valid/ready handshake, applies
// prioritised redirects, reports misaligned redirect targets and supports
// a halt (WFI) state with wake-up.
//   clk, reset_n      - clock, synchronous active-low reset
//   fetch             - fetch handshake (pc_valid, pc out; fetch_ready in)
//   trapped/trap_target, trap_return/epc, jump/jump_target,
//   branch_taken/branch_base/branch_offset - redirect requests
//   halt_req, wake    - WFI retired / pending enabled interrupt
//   redirect          - pulse: redirect accepted, flush IF/ID
//   misaligned        - pulse: redirect target misaligned
//   misaligned_addr   - last misaligned target, held until the next one
//
// state | meaning
// BOOT  | first cycle after reset, pc not yet valid, inputs ignored
// RUN   | offering pc to IF, advancing on handshake, taking redirects
// HALT  | WFI: pc not offered, waiting for wake or a redirect
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
  parameter int              IALIGN       = 32,
  parameter int              STEP         = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pc_sequencer_if.master        fetch,
  input  logic                  trapped,
  input  logic [XLEN-1:0]       trap_target,
  input  logic                  trap_return,
  input  logic [XLEN-1:0]       epc,
  input  logic                  jump,
  input  logic [XLEN-1:0]       jump_target,
  input  logic                  branch_taken,
  input  logic [XLEN-1:0]       branch_base,
  input  logic [XLEN-1:0]       branch_offset,
  input  logic                  halt_req,
  input  logic                  wake,
  output logic                  redirect,
  output logic                  misaligned,
  output logic [XLEN-1:0]       misaligned_addr
);

  localparam logic [1:0] S_BOOT = 2'(ST_BOOT);
  localparam logic [1:0] S_RUN  = 2'(ST_RUN);
  localparam logic [1:0] S_HALT = 2'(ST_HALT);

  logic [1:0]      state_q;
  logic [XLEN-1:0] pc_q;
  logic            valid_q;
  logic            redirect_q;
  logic            mis_q;
  logic [XLEN-1:0] maddr_q;

  redir_src_e      arb_sel;
  logic [XLEN-1:0] arb_target;
  logic            arb_mis;
  logic            take_redirect;

  pc_target_arbiter #(
    .XLEN   (XLEN),
    .IALIGN (IALIGN)
  ) u_arbiter (
    .trapped       (trapped),
    .trap_target   (trap_target),
    .trap_return   (trap_return),
    .epc           (epc),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_base   (branch_base),
    .branch_offset (branch_offset),
    .sel           (arb_sel),
    .target        (arb_target),
    .misaligned    (arb_mis)
  );

  assign take_redirect = (arb_sel != SRC_NONE) && !arb_mis;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_VECTOR;
      valid_q    <= 1'b0;
      redirect_q <= 1'b0;
      mis_q      <= 1'b0;
      maddr_q    <= '0;
    end else begin
      redirect_q <= 1'b0;
      mis_q      <= 1'b0;
      case (state_q)
        S_BOOT: begin
          state_q <= S_RUN;
          valid_q <= 1'b1;
        end
        S_RUN, S_HALT: begin
          if (take_redirect) begin
            // Overrides a stalled pc: the unaccepted address is dropped.
            pc_q       <= arb_target;
            state_q    <= S_RUN;
            valid_q    <= 1'b1;
            redirect_q <= 1'b1;
          end else if (arb_mis) begin
            // Rejected redirect freezes the sequencer for this cycle;
            // the exception itself is raised upstream.
            mis_q   <= 1'b1;
            maddr_q <= arb_target;
          end else if (state_q == S_RUN) begin
            if (valid_q && fetch.fetch_ready) begin
              pc_q <= pc_q + XLEN'(STEP);
            end
            if (halt_req) begin
              state_q <= S_HALT;
              valid_q <= 1'b0;
            end
          end else if (wake) begin
            state_q <= S_RUN;
            valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_BOOT;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign fetch.pc        = pc_q;
  assign fetch.pc_valid  = valid_q;
  assign redirect        = redirect_q;
  assign misaligned      = mis_q;
  assign misaligned_addr = maddr_q;

endmodule
